// File: rtl/gray_to_rgb565_stream_pkg.sv
// Shared definitions for the gray <-> RGB565 stream stages: expander state
// encoding and the RGB565 field widths used by both conversion directions.
package gray_to_rgb565_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  localparam int R_BITS   = 5;
  localparam int G_BITS   = 6;
  localparam int B_BITS   = 5;
  localparam int PIX_BITS = R_BITS + G_BITS + B_BITS;

endpackage

// File: rtl/gray_to_rgb565_pixel.sv
// Combinational 8-bit gray -> 16-bit RGB565 mapping; each channel takes the
// top bits of the gray value, optionally byte-swapped for big-endian buses.
module gray_to_rgb565_pixel
  import gray_to_rgb565_stream_pkg::*;
#(
  parameter int SWAP_BYTES = 0
) (
  input  logic [7:0]  gray,
  output logic [15:0] rgb
);

  logic [PIX_BITS-1:0] native;

  assign native = {gray[7 -: R_BITS], gray[7 -: G_BITS], gray[7 -: B_BITS]};
  assign rgb    = (SWAP_BYTES != 0) ? {native[7:0], native[15:8]} : native;

endmodule

// File: rtl/gray_to_rgb565_stream.sv
// Streaming expander: one 32-bit word of four gray pixels becomes two 32-bit
// words of two RGB565 pixels each, low pixel pair first.
module gray_to_rgb565_stream
  import gray_to_rgb565_stream_pkg::*;
#(
  parameter int SWAP_BYTES  = 0,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [31:0]            grayIn,
  input  logic                   grayValid,
  output logic                   grayReady,
  output logic [31:0]            rgbOut,
  output logic                   rgbValid,
  input  logic                   rgbReady,
  output logic [COUNT_WIDTH-1:0] wordCount
);

  state_t      state;
  logic [31:0] buf_word;
  logic [15:0] src_pair;
  logic [31:0] next_word;
  logic        in_xfer;
  logic        out_xfer;

  // HI accepts a new word only when its own output leaves in the same cycle.
  assign grayReady = (state == EMPTY) || ((state == HI) && rgbReady);
  assign in_xfer   = grayValid && grayReady;
  assign out_xfer  = rgbValid && rgbReady;

  // In LO the next word is the buffered high pair; otherwise it is the low
  // pair of the incoming word, which is what both EMPTY and HI latch.
  assign src_pair = (state == LO) ? buf_word[31:16] : grayIn[15:0];

  gray_to_rgb565_pixel #(.SWAP_BYTES(SWAP_BYTES)) u_pix_lo (
    .gray (src_pair[7:0]),
    .rgb  (next_word[15:0])
  );

  gray_to_rgb565_pixel #(.SWAP_BYTES(SWAP_BYTES)) u_pix_hi (
    .gray (src_pair[15:8]),
    .rgb  (next_word[31:16])
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      buf_word  <= '0;
      rgbOut    <= '0;
      rgbValid  <= 1'b0;
      wordCount <= '0;
    end else if (clear) begin
      // buf_word is left stale: it is only read after the next latch.
      state     <= EMPTY;
      rgbValid  <= 1'b0;
      wordCount <= '0;
    end else begin
      if (out_xfer) wordCount <= wordCount + 1'b1;
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            buf_word <= grayIn;
            rgbOut   <= next_word;
            rgbValid <= 1'b1;
            state    <= LO;
          end
        end
        LO: begin
          if (out_xfer) begin
            rgbOut <= next_word;
            state  <= HI;
          end
        end
        HI: begin
          if (out_xfer) begin
            if (in_xfer) begin
              buf_word <= grayIn;
              rgbOut   <= next_word;
              state    <= LO;
            end else begin
              rgbValid <= 1'b0;
              state    <= EMPTY;
            end
          end
        end
        default: begin
          rgbValid <= 1'b0;
          state    <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_to_rgb565_stream.sv
// Self-checking bench: two instances (native order / 32-bit count, swapped
// order / 3-bit count) driven in lockstep against a queue-based reference.
module tb_gray_to_rgb565_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] grayIn = '0;
  logic        grayValid = 1'b0;
  logic        rgbReady = 1'b0;

  logic        grayReady0, grayReady1;
  logic        rgbValid0, rgbValid1;
  logic [31:0] rgbOut0, rgbOut1;
  logic [31:0] wordCount0;
  logic [2:0]  wordCount1;

  int tests_run = 0;
  int tests_failed = 0;

  gray_to_rgb565_stream #(.SWAP_BYTES(0), .COUNT_WIDTH(32)) dut0 (
    .clock(clock), .reset(reset), .clear(clear),
    .grayIn(grayIn), .grayValid(grayValid), .grayReady(grayReady0),
    .rgbOut(rgbOut0), .rgbValid(rgbValid0), .rgbReady(rgbReady),
    .wordCount(wordCount0)
  );

  gray_to_rgb565_stream #(.SWAP_BYTES(1), .COUNT_WIDTH(3)) dut1 (
    .clock(clock), .reset(reset), .clear(clear),
    .grayIn(grayIn), .grayValid(grayValid), .grayReady(grayReady1),
    .rgbOut(rgbOut1), .rgbValid(rgbValid1), .rgbReady(rgbReady),
    .wordCount(wordCount1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference pixel: scale gray into 5/6/5-bit channels by integer division.
  function automatic logic [15:0] ref_pix(input int g, input bit sw);
    int r5, g6, v;
    r5 = g / 8;
    g6 = g / 4;
    v  = r5 * 2048 + g6 * 32 + r5;
    if (sw) v = (v % 256) * 256 + (v / 256);
    return v[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w, input int pair, input bit sw);
    int lo_g, hi_g;
    lo_g = (w >> (16 * pair)) & 32'hFF;
    hi_g = (w >> (16 * pair + 8)) & 32'hFF;
    return {ref_pix(hi_g, sw), ref_pix(lo_g, sw)};
  endfunction

  // Reference state: pending output words for each instance plus a count.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int unsigned model_cnt = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_out0, prev_out1;

  task automatic model_flush();
    q0.delete();
    q1.delete();
    model_cnt = 0;
    prev_hold = 1'b0;
  endtask

  // One cycle: entered #1 after a rising edge, returns #1 after the next one.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                      input logic clr, output bit accepted);
    bit exp_gr, in_x, out_x;
    grayValid = v;
    grayIn    = d;
    rgbReady  = rdy;
    clear     = clr;
    #1;
    exp_gr = (q0.size() == 0) || (q0.size() == 1 && rdy);
    check("gray_ready0", grayReady0, exp_gr);
    check("gray_ready1", grayReady1, exp_gr);
    check("rgb_valid0", rgbValid0, q0.size() != 0);
    check("rgb_valid1", rgbValid1, q1.size() != 0);
    check("word_count0", wordCount0, model_cnt);
    check("word_count1", wordCount1, model_cnt % 8);
    if (prev_hold) begin
      check("stall_hold0", rgbOut0, prev_out0);
      check("stall_hold1", rgbOut1, prev_out1);
    end
    if (q0.size() != 0 && rdy && !clr) begin
      check("rgb_out0", rgbOut0, q0[0]);
      check("rgb_out1", rgbOut1, q1[0]);
    end
    in_x      = v && exp_gr && !clr;
    out_x     = (q0.size() != 0) && rdy && !clr;
    prev_hold = (q0.size() != 0) && !rdy && !clr;
    prev_out0 = rgbOut0;
    prev_out1 = rgbOut1;
    accepted  = in_x;
    @(posedge clock);
    if (clr) begin
      model_flush();
    end else begin
      if (out_x) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        model_cnt++;
      end
      if (in_x) begin
        q0.push_back(ref_word(d, 0, 1'b0));
        q0.push_back(ref_word(d, 1, 1'b0));
        q1.push_back(ref_word(d, 0, 1'b1));
        q1.push_back(ref_word(d, 1, 1'b1));
      end
    end
    #1;
  endtask

  typedef struct {
    logic [31:0] gray;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] lo_sw;
    logic [31:0] hi_sw;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit acc;
    int sent, steps, valid_cycles;

    vecs[0] = '{32'h100080FF, 32'h8410FFFF, 32'h10820000, 32'h1084FFFF, 32'h82100000};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'h04087F80, 32'h7BEF8410, 32'h00200841, 32'hEF7B1084, 32'h20004108};

    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_gray_ready", grayReady0, 1'b1);
    check("rst_rgb_valid", rgbValid0, 1'b0);
    check("rst_rgb_out", rgbOut0, 32'h0);
    check("rst_word_count", wordCount0, 32'h0);

    // Fixed vectors, one input word each, downstream always ready.
    for (int i = 0; i < 4; i++) begin
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      grayValid = 1'b1;
      grayIn    = vecs[i].gray;
      rgbReady  = 1'b1;
      @(posedge clock); #1;
      grayValid = 1'b0;
      check("vec_lo_valid", rgbValid0, 1'b1);
      check("vec_lo", rgbOut0, vecs[i].lo);
      check("vec_lo_sw", rgbOut1, vecs[i].lo_sw);
      @(posedge clock); #1;
      check("vec_hi", rgbOut0, vecs[i].hi);
      check("vec_hi_sw", rgbOut1, vecs[i].hi_sw);
      @(posedge clock); #1;
      check("vec_done_valid", rgbValid0, 1'b0);
      check("vec_count", wordCount0, 32'd2);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    model_flush();

    // Eight back-to-back words: 16 output words with no bubble after the first.
    sent = 0; steps = 0; valid_cycles = 0;
    while ((sent < 8 || q0.size() != 0) && steps < 40) begin
      if (q0.size() != 0) valid_cycles++;
      step(sent < 8, $urandom, 1'b1, 1'b0, acc);
      if (acc) sent++;
      steps++;
    end
    check("burst_steps", steps, 17);
    check("burst_valid_cycles", valid_cycles, 16);
    check("burst_count", wordCount0, 32'd16);
    check("burst_count_wrap", wordCount1, 3'd0);

    // Backpressure in LO for five cycles, then drain both halves.
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);
    step(1'b1, 32'hA55A3CC3, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h12345678, 1'b0, 1'b0, acc);
    check("stall_gray_ready", grayReady0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    check("stall_count", wordCount0, 32'd2);

    // Clear while HI holds a pending word, then a fresh word.
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, acc);
    check("clear_valid", rgbValid0, 1'b0);
    check("clear_count", wordCount0, 32'd0);
    check("clear_gray_ready", grayReady0, 1'b1);
    step(1'b1, 32'h0180FE7F, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Asynchronous reset pulse between edges, mid-stream.
    step(1'b1, 32'h11223344, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", rgbValid0, 1'b0);
    check("async_rst_count", wordCount0, 32'd0);
    #2 reset = 1'b0;
    model_flush();
    @(posedge clock); #1;
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, acc);
    check("post_rst_lo", rgbOut0, 32'hFFFFFFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    check("post_rst_hi", rgbOut0, 32'hFFFFFFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Random traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
